// File: rtl/word_serdes_pkg.sv
// Shared types and helpers for the word_serdes parallel<->serial converter pair.
package word_serdes_pkg;

    typedef logic [0:0] tx_state_t;

    localparam tx_state_t TX_IDLE = 1'b0;
    localparam tx_state_t TX_SEND = 1'b1;

    // Width of a counter that has to reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/word_serdes_beat_counter.sv
// Modulo-NUM_WORDS beat counter with wrap flag on the final beat of a word.
module beat_counter
    import word_serdes_pkg::*;
#(
    parameter int NUM_WORDS = 4
) (
    input  logic clk,
    input  logic i_reset,
    input  logic inc,
    input  logic clear,
    output logic wrap
);

    localparam int CW = cnt_width(NUM_WORDS);

    logic [CW-1:0] count;

    assign wrap = inc && (count == CW'(NUM_WORDS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (clear || wrap) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/word_serdes.sv
// Word-level serializer (wide word -> WIDTH-bit beats) and independent deserializer.
module word_serdes
    import word_serdes_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int NUM_WORDS     = 4,
    parameter bit LITTLE_ENDIAN = 1'b0
) (
    input  logic                       clk,
    input  logic                       i_reset,
    input  logic [WIDTH*NUM_WORDS-1:0] ser_i_data,
    input  logic                       ser_i_dv,
    output logic [WIDTH-1:0]           ser_o_data,
    output logic                       ser_o_dv,
    output logic                       ser_o_busy,
    input  logic [WIDTH-1:0]           des_i_data,
    input  logic                       des_i_dv,
    output logic [WIDTH*NUM_WORDS-1:0] des_o_data,
    output logic                       des_o_dv
);

    localparam int W = WIDTH * NUM_WORDS;

    // Beat that leaves first, and the word with that beat consumed.
    function automatic logic [WIDTH-1:0] lead_beat(input logic [W-1:0] w);
        return LITTLE_ENDIAN ? w[WIDTH-1:0] : w[W-1 -: WIDTH];
    endfunction

    function automatic logic [W-1:0] drop_beat(input logic [W-1:0] w);
        return LITTLE_ENDIAN ? (w >> WIDTH) : (w << WIDTH);
    endfunction

    // ---------------- serializer ----------------
    tx_state_t      tx_state;
    logic [W-1:0]   tx_shreg;
    logic           tx_wrap;
    logic           tx_accept;

    beat_counter #(.NUM_WORDS(NUM_WORDS)) u_tx_cnt (
        .clk     (clk),
        .i_reset (i_reset),
        .inc     (tx_state == TX_SEND),
        .clear   (tx_state == TX_IDLE),
        .wrap    (tx_wrap)
    );

    // A new word is taken when idle or while the last beat is on the wire.
    assign tx_accept  = ser_i_dv && ((tx_state == TX_IDLE) || tx_wrap);
    assign ser_o_busy = (tx_state == TX_SEND);

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            tx_state   <= TX_IDLE;
            tx_shreg   <= '0;
            ser_o_data <= '0;
            ser_o_dv   <= 1'b0;
        end else if (tx_accept) begin
            tx_state   <= TX_SEND;
            tx_shreg   <= drop_beat(ser_i_data);
            ser_o_data <= lead_beat(ser_i_data);
            ser_o_dv   <= 1'b1;
        end else if (tx_state == TX_SEND) begin
            if (tx_wrap) begin
                tx_state <= TX_IDLE;
                ser_o_dv <= 1'b0;
            end else begin
                tx_shreg   <= drop_beat(tx_shreg);
                ser_o_data <= lead_beat(tx_shreg);
            end
        end
    end

    // ---------------- deserializer ----------------
    logic [W-1:0] rx_shreg;
    logic [W-1:0] rx_next;
    logic         rx_wrap;

    beat_counter #(.NUM_WORDS(NUM_WORDS)) u_rx_cnt (
        .clk     (clk),
        .i_reset (i_reset),
        .inc     (des_i_dv),
        .clear   (1'b0),
        .wrap    (rx_wrap)
    );

    // Earlier beats migrate toward the end of the word where the first beat belongs.
    assign rx_next = LITTLE_ENDIAN ? {des_i_data, rx_shreg[W-1:WIDTH]}
                                   : {rx_shreg[W-WIDTH-1:0], des_i_data};

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_shreg   <= '0;
            des_o_data <= '0;
            des_o_dv   <= 1'b0;
        end else begin
            des_o_dv <= rx_wrap;
            if (des_i_dv) begin
                rx_shreg <= rx_next;
            end
            if (rx_wrap) begin
                des_o_data <= rx_next;
            end
        end
    end

endmodule

// File: tb/tb_word_serdes.sv
// Bench for word_serdes: MSB-first and LSB-first instances, queue-based model, directed vectors.
module tb_word_serdes;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] ser_i_data = '0;
    logic        ser_i_dv = 1'b0;
    logic        loop = 1'b1;
    logic [7:0]  tb_des_data = '0;
    logic        tb_des_dv = 1'b0;

    logic [7:0]  so_data [2];
    logic        so_dv   [2];
    logic        so_busy [2];
    logic [31:0] do_data [2];
    logic        do_dv   [2];
    logic [7:0]  di_data [2];
    logic        di_dv   [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign di_data[g] = loop ? so_data[g] : tb_des_data;
        assign di_dv[g]   = loop ? so_dv[g]   : tb_des_dv;

        word_serdes #(.WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(g == 1)) dut (
            .clk        (clk),
            .i_reset    (i_reset),
            .ser_i_data (ser_i_data),
            .ser_i_dv   (ser_i_dv),
            .ser_o_data (so_data[g]),
            .ser_o_dv   (so_dv[g]),
            .ser_o_busy (so_busy[g]),
            .des_i_data (di_data[g]),
            .des_i_dv   (di_dv[g]),
            .des_o_data (do_data[g]),
            .des_o_dv   (do_dv[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- model: frames as queues of pending beats ----------------
    logic [7:0]  txq  [2][$];
    logic [7:0]  part [2][$];
    logic [7:0]  last_beat [2] = '{default: '0};
    logic [31:0] exp_do_data [2] = '{default: '0};
    logic        exp_do_dv   [2] = '{default: 1'b0};

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!i_reset) begin
                txq[m].delete();
                part[m].delete();
                last_beat[m]   = '0;
                exp_do_data[m] = '0;
                exp_do_dv[m]   = 1'b0;
            end else begin
                logic       rx_dv;
                logic [7:0] rx_d;
                logic       acc;
                rx_dv = loop ? (txq[m].size() > 0) : tb_des_dv;
                rx_d  = (loop && txq[m].size() > 0) ? txq[m][0] : tb_des_data;
                acc   = ser_i_dv && (txq[m].size() <= 1);
                if (txq[m].size() > 0) last_beat[m] = txq[m].pop_front();
                if (acc) begin
                    for (int k = 0; k < 4; k++)
                        txq[m].push_back(m == 1 ? ser_i_data[k*8 +: 8] : ser_i_data[(3-k)*8 +: 8]);
                end
                exp_do_dv[m] = 1'b0;
                if (rx_dv) begin
                    part[m].push_back(rx_d);
                    if (part[m].size() == 4) begin
                        for (int k = 0; k < 4; k++)
                            exp_do_data[m][(m == 1 ? k : 3 - k)*8 +: 8] = part[m][k];
                        exp_do_dv[m] = 1'b1;
                        part[m].delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (i_reset) begin
            for (int m = 0; m < 2; m++) begin
                check($sformatf("m%0d ser_o_dv", m), 32'(so_dv[m]), 32'(txq[m].size() > 0));
                check($sformatf("m%0d ser_o_busy", m), 32'(so_busy[m]), 32'(txq[m].size() > 0));
                check($sformatf("m%0d ser_o_data", m), 32'(so_data[m]),
                      32'(txq[m].size() > 0 ? txq[m][0] : last_beat[m]));
                check($sformatf("m%0d des_o_dv", m), 32'(do_dv[m]), 32'(exp_do_dv[m]));
                check($sformatf("m%0d des_o_data", m), do_data[m], exp_do_data[m]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_and_check(input logic [31:0] w, input string tag);
        logic [31:0] le_order;
        le_order = {w[7:0], w[15:8], w[23:16], w[31:24]};
        ser_i_data = w;
        ser_i_dv   = 1'b1;
        step(1);
        ser_i_dv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s msb beat%0d", tag, k), {23'd0, so_dv[0], so_data[0]},
                  {23'd0, 1'b1, w[(3-k)*8 +: 8]});
            check($sformatf("%s lsb beat%0d", tag, k), {23'd0, so_dv[1], so_data[1]},
                  {23'd0, 1'b1, le_order[(3-k)*8 +: 8]});
            step(1);
        end
        check({tag, " ser idle"}, 32'(so_dv[0]), 32'd0);
        check({tag, " ser hold"}, 32'(so_data[0]), 32'(w[7:0]));
        check({tag, " msb des_dv"}, 32'(do_dv[0]), 32'd1);
        check({tag, " msb word"}, do_data[0], w);
        check({tag, " lsb des_dv"}, 32'(do_dv[1]), 32'd1);
        check({tag, " lsb word"}, do_data[1], w);
        step(1);
        check({tag, " des_dv one cycle"}, 32'(do_dv[0]), 32'd0);
        check({tag, " des_data hold"}, do_data[0], w);
    endtask

    task automatic rx_beat(input logic [7:0] b);
        tb_des_data = b;
        tb_des_dv   = 1'b1;
        step(1);
        tb_des_dv = 1'b0;
    endtask

    initial begin
        int n_dv;
        step(2);
        check("reset ser_o_dv", 32'(so_dv[0]), 32'd0);
        check("reset ser_o_data", 32'(so_data[0]), 32'd0);
        check("reset busy", 32'(so_busy[0]), 32'd0);
        check("reset des_o_data", do_data[1], 32'd0);
        i_reset = 1'b1;
        step(2);

        // 1/3: loopback, both byte orders
        send_and_check(32'h12345678, "t1");
        // 2: after an idle gap
        step(3);
        send_and_check(32'h9abcdef0, "t2");

        // 4: RX alone with a gap inside the word
        loop = 1'b0;
        step(1);
        rx_beat(8'h12);
        rx_beat(8'h34);
        for (int i = 0; i < 5; i++) begin
            check("t4 no early des_dv", 32'(do_dv[0]), 32'd0);
            step(1);
        end
        rx_beat(8'h56);
        rx_beat(8'h78);
        check("t4 msb des_dv", 32'(do_dv[0]), 32'd1);
        check("t4 msb word", do_data[0], 32'h12345678);
        check("t4 lsb word", do_data[1], 32'h78563412);

        // 5: drop mid-frame request, accept on last beat
        loop = 1'b1;
        step(2);
        ser_i_data = 32'h11223344;
        ser_i_dv   = 1'b1;
        n_dv = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (so_dv[0]) n_dv++;
            if (i == 5) check("t5 word1", do_data[0], 32'h11223344);
            if (i == 9) check("t5 word2", do_data[0], 32'h55667788);
            ser_i_dv   = (i == 2) || (i == 4);
            ser_i_data = (i == 2) ? 32'haaaaaaaa : 32'h55667788;
        end
        check("t5 ser_o_dv cycles", n_dv, 32'd8);

        // 6: reset mid-frame on both TX and RX
        loop = 1'b0;
        ser_i_data = 32'hcafef00d;
        ser_i_dv   = 1'b1;
        tb_des_data = 8'hde;
        tb_des_dv   = 1'b1;
        step(1);
        ser_i_dv    = 1'b0;
        tb_des_data = 8'had;
        step(1);
        tb_des_dv = 1'b0;
        i_reset   = 1'b0;
        #1;
        check("t6 reset ser_o_dv", 32'(so_dv[0]), 32'd0);
        check("t6 reset ser_o_data", 32'(so_data[0]), 32'd0);
        check("t6 reset des_o_data", do_data[0], 32'd0);
        step(2);
        i_reset = 1'b1;
        step(1);
        check("t6 no ser after reset", 32'(so_dv[0]), 32'd0);
        rx_beat(8'h01);
        rx_beat(8'h02);
        rx_beat(8'h03);
        check("t6 no des_dv on 3 beats", 32'(do_dv[0]), 32'd0);
        rx_beat(8'h04);
        check("t6 msb des_dv", 32'(do_dv[0]), 32'd1);
        check("t6 msb word", do_data[0], 32'h01020304);
        check("t6 lsb word", do_data[1], 32'h04030201);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
